// File: rtl/bridge_pkg.sv
// Shared constants, types and helpers for the CPU data-port bridge.
package bridge_pkg;

   localparam logic [19:0] MMIO_BASE = 20'hFFFFF;

   localparam logic [11:0] OFF_DIG   = 12'h000;
   localparam logic [11:0] OFF_TCNT  = 12'h020;
   localparam logic [11:0] OFF_TCMP  = 12'h024;
   localparam logic [11:0] OFF_TCTRL = 12'h028;
   localparam logic [11:0] OFF_TSTAT = 12'h02C;
   localparam logic [11:0] OFF_LED   = 12'h060;
   localparam logic [11:0] OFF_SW    = 12'h070;
   localparam logic [11:0] OFF_BTN   = 12'h078;

   // Packed MSB-first, so enable lands on bit 0 and autoreload on bit 1.
   typedef struct packed {
      logic autoreload;
      logic enable;
   } tctrl_t;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  sel);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/mmio_timer.sv
// Compare timer: prescaler, TCNT/TCMP/TCTRL registers and the sticky match flag.
module mmio_timer
   import bridge_pkg::*;
#(
   parameter int TIMER_DIV = 50
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_tcnt,
   input  logic        wr_tcmp,
   input  logic        wr_tctrl,
   input  logic        wr_tstat,
   input  logic [3:0]  sel,
   input  logic [31:0] wdata,
   output logic [31:0] tcnt,
   output logic [31:0] tcmp,
   output logic [1:0]  tctrl_bits,
   output logic        flag
);

   localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TIMER_DIV - 1);

   logic [PW-1:0] presc;
   tctrl_t        ctrl;
   tctrl_t        ctrl_next;
   logic          enable_rise;
   logic          tick;
   logic          match;
   logic          clear_req;

   assign ctrl_next   = sel[0] ? tctrl_t'(wdata[1:0]) : ctrl;
   assign enable_rise = wr_tctrl & ~ctrl.enable & ctrl_next.enable;
   assign tick        = ctrl.enable & (presc == PRE_MAX);
   assign match       = (tcnt == tcmp);
   assign clear_req   = wr_tstat & (sel != 4'b0000) & wdata[0];
   assign tctrl_bits  = ctrl;

   // Turning the timer on restarts the prescaler so the first tick is a full period away.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
      end else if (enable_rise) begin
         presc <= '0;
      end else if (ctrl.enable) begin
         presc <= tick ? '0 : presc + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl <= '0;
         tcmp <= '0;
      end else begin
         if (wr_tctrl) ctrl <= ctrl_next;
         if (wr_tcmp)  tcmp <= byte_merge(tcmp, wdata, sel);
      end
   end

   // A software write to TCNT overrides the tick update in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt <= '0;
      end else if (wr_tcnt) begin
         tcnt <= byte_merge(tcnt, wdata, sel);
      end else if (tick) begin
         tcnt <= (match & ctrl.autoreload) ? '0 : tcnt + 32'd1;
      end
   end

   // A match arriving together with a write-1-to-clear keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag <= 1'b0;
      end else if (tick & match) begin
         flag <= 1'b1;
      end else if (clear_req) begin
         flag <= 1'b0;
      end
   end

endmodule

// File: rtl/data_bus_bridge.sv
// CPU data-port responder: splits accesses between word-addressed DRAM and a small MMIO page.
module data_bus_bridge
   import bridge_pkg::*;
#(
   parameter int MEM_AW    = 14,
   parameter int TIMER_DIV = 50,
   parameter int SW_W      = 24,
   parameter int BTN_W     = 5
) (
   input  logic              cpu_clk,
   input  logic              cpu_rst,
   input  logic [31:0]       dram_addr,
   input  logic              dram_we,
   input  logic [3:0]        dram_sel,
   input  logic [31:0]       dram_wdata,
   output logic [31:0]       dram_rdata,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic [SW_W-1:0]   sw_in,
   input  logic [BTN_W-1:0]  btn_in,
   output logic [SW_W-1:0]   led_out,
   output logic [31:0]       dig_out,
   output logic              timer_irq
);

   logic              mmio;
   logic [11:0]       offset;
   logic              mmio_wr;
   logic [31:0]       mmio_rdata;
   logic [SW_W-1:0]   sw_meta;
   logic [SW_W-1:0]   sw_sync;
   logic [BTN_W-1:0]  btn_meta;
   logic [BTN_W-1:0]  btn_sync;
   logic [31:0]       tcnt;
   logic [31:0]       tcmp;
   logic [1:0]        tctrl_bits;
   logic              flag;

   assign mmio    = (dram_addr[31:12] == MMIO_BASE);
   assign offset  = dram_addr[11:0];
   assign mmio_wr = dram_we & mmio;

   // Sub-word stores rebuild the full word from the current DRAM contents.
   assign mem_addr  = dram_addr[MEM_AW+1:2];
   assign mem_we    = dram_we & ~mmio & (dram_sel != 4'b0000);
   assign mem_wdata = byte_merge(mem_rdata, dram_wdata, dram_sel);

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         sw_meta  <= '0;
         sw_sync  <= '0;
         btn_meta <= '0;
         btn_sync <= '0;
      end else begin
         sw_meta  <= sw_in;
         sw_sync  <= sw_meta;
         btn_meta <= btn_in;
         btn_sync <= btn_meta;
      end
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         dig_out <= '0;
         led_out <= '0;
      end else if (mmio_wr) begin
         if (offset == OFF_DIG) dig_out <= byte_merge(dig_out, dram_wdata, dram_sel);
         if (offset == OFF_LED) led_out <= SW_W'(byte_merge(32'(led_out), dram_wdata, dram_sel));
      end
   end

   mmio_timer #(
      .TIMER_DIV(TIMER_DIV)
   ) u_timer (
      .clk       (cpu_clk),
      .rst       (cpu_rst),
      .wr_tcnt   (mmio_wr & (offset == OFF_TCNT)),
      .wr_tcmp   (mmio_wr & (offset == OFF_TCMP)),
      .wr_tctrl  (mmio_wr & (offset == OFF_TCTRL)),
      .wr_tstat  (mmio_wr & (offset == OFF_TSTAT)),
      .sel       (dram_sel),
      .wdata     (dram_wdata),
      .tcnt      (tcnt),
      .tcmp      (tcmp),
      .tctrl_bits(tctrl_bits),
      .flag      (flag)
   );

   assign timer_irq = flag;

   always_comb begin
      mmio_rdata = '0;
      case (offset)
         OFF_DIG:   mmio_rdata = dig_out;
         OFF_TCNT:  mmio_rdata = tcnt;
         OFF_TCMP:  mmio_rdata = tcmp;
         OFF_TCTRL: mmio_rdata = {30'b0, tctrl_bits};
         OFF_TSTAT: mmio_rdata = {31'b0, flag};
         OFF_LED:   mmio_rdata = 32'(led_out);
         OFF_SW:    mmio_rdata = 32'(sw_sync);
         OFF_BTN:   mmio_rdata = 32'(btn_sync);
         default:   mmio_rdata = '0;
      endcase
      dram_rdata = mmio ? mmio_rdata : mem_rdata;
   end

endmodule
